obstacle_nav_fsm: RTL and testbench
===================================

// Module: obstacle_nav_fsm
// PURPOSE
//  Parametrised obstacle-avoidance controller for the two-motor car. Samples N_IR active-low IR sensors,
//  synchronises and debounces them, then runs a timed FSM (start, forward, reverse back-off, pivot turn,
//  stuck). Drives the 4-line H-bridge motor bus. Replaces the free-running sensor decode and external
//  slow-clock generator with an internal tick prescaler. Sits between the sensor pins and the motor pins.
// PARAMETERS
//  N_IR        4        number of IR sensors (>=2)
//  FRONT_MASK  4'b0001  sensors that count as front obstacle
//  LEFT_MASK   4'b0010  sensors that count as left obstacle
//  RIGHT_MASK  4'b0100  sensors that count as right obstacle
//  REAR_MASK   4'b1000  sensors that count as rear obstacle (aborts back-off)
//  TICK_DIV    50000    clk cycles per FSM timing tick (>=2)
//  DEB_CYC     8        consecutive equal samples required to accept a sensor change (>=1)
//  START_TICKS 10       brake time in IDLE after enable before moving
//  BACK_TICKS  20       reverse duration in BACKOFF
//  TURN_TICKS  15       pivot duration per TURN attempt
//  MAX_RETRY   3        consecutive turn attempts with front still blocked before STUCK
// PORTS
//  clk        in   1      system clock
//  rst_n      in   1      asynchronous active-low reset
//  en         in   1      run enable; low forces IDLE/brake
//  ir_n       in   N_IR   raw sensor pins, 0 = obstacle
//  motor_fin  out  4      H-bridge lines {fin1,fin2,fin3,fin4}
//  state_o    out  3      current FSM state code
//  obst_o     out  N_IR   debounced obstacle flags, 1 = obstacle
//  stuck_o    out  1      high while in STUCK
// BEHAVIOUR
//  Reset (async assert, sync release): motor_fin=BRAKE 4'b1111, state_o=IDLE, obst_o=0, stuck_o=0,
//    prescaler/timer/retry=0, turn-toggle=0.
//  Motor codes: FWD 4'b0110, REV 4'b1001, PIV_L 4'b1101, PIV_R 4'b1011, BRAKE 4'b1111.
//  Sensor path: 2-flop sync, then per-bit counter; obst flag flips after DEB_CYC consecutive samples
//    differing from the current flag. Pin-to-obst_o latency = 2+DEB_CYC cycles.
//  F/L/R/B = |(obst & mask). Prescaler counts 0..TICK_DIV-1; tick pulses 1 cycle on wrap. It runs
//    continuously and is not reset by state changes. Timer counts ticks, cleared on every state entry.
//  FSM registered; motor_fin/state_o/stuck_o update in the same cycle as the state; decision lag = 1 clk.
//   IDLE: BRAKE. en && timer==START_TICKS -> FWD. Timer holds at 0 while en low.
//   FWD: F or (L&&R) -> BACKOFF; else L -> TURN_R; else R -> TURN_L; else stay. Priority in that order.
//   BACKOFF: REV. timer==BACK_TICKS or B -> turn choice: L&&!R -> TURN_R; R&&!L -> TURN_L;
//     otherwise TURN_L if toggle=0, else TURN_R, then invert toggle.
//   TURN_L/TURN_R: PIV_L/PIV_R. At timer==TURN_TICKS: !F -> FWD, retry=0; else retry+1, re-enter same
//     turn (timer cleared); when retry reaches MAX_RETRY -> STUCK.
//   STUCK: BRAKE, stuck_o=1; exits only via en low.
//  en low in any state -> IDLE next cycle, retry=0. Enable has priority over all transitions.
//  Retry resets to 0 on entry to FWD or IDLE only.
//  All counters are width $clog2(max+1) and saturate, never wrap. Illegal state -> IDLE.
//  Mid-operation reset: immediate BRAKE; no state retained.
// STRUCTURE
//  car_pkg: state encodings (IDLE=0,FWD=1,BACKOFF=2,TURN_L=3,TURN_R=4,STUCK=5) and motor code constants.
//  Sub-module ir_debounce (one bit, DEB_CYC param), instantiated N_IR times via generate.
//  Prescaler, timer, retry counter and FSM stay in this module.
// TESTING (TICK_DIV=4, DEB_CYC=3, START=2, BACK=2, TURN=3, MAX_RETRY=2, N_IR=4)
//  1 Reset/start: rst_n low, en=1, ir_n=4'hF -> BRAKE; after release, FWD 4'b0110 within 2 ticks (+1 clk).
//  2 Debounce: 2-cycle glitch on ir_n[0] -> obst_o stays 0, no state change; 6-cycle low -> obst_o[0]=1
//    at 5 clk, then BACKOFF/REV next clk.
//  3 Side: ir_n=4'b1101 in FWD -> TURN_R 4'b1011; clear before 3 ticks end -> FWD, retry=0.
//  4 Back-off: front blocked, L=R=0 -> REV for 2 ticks, TURN_L; repeat -> TURN_R (toggle). Rear blocked
//    during REV -> turn on next clk.
//  5 Stuck: front held blocked -> 2 turn periods then STUCK, stuck_o=1, BRAKE; en low -> IDLE, stuck_o=0.
//  6 en/reset mid-TURN: en=0 -> IDLE BRAKE next clk; rst_n pulse -> async BRAKE, counters 0.

Source files
------------

// File: rtl/car_pkg.sv
// Shared state encodings and H-bridge drive codes for the obstacle-avoidance car.
package car_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_FWD     = 3'd1,
    ST_BACKOFF = 3'd2,
    ST_TURN_L  = 3'd3,
    ST_TURN_R  = 3'd4,
    ST_STUCK   = 3'd5
  } state_e;

  // {fin1,fin2,fin3,fin4}
  localparam logic [3:0] MOTOR_FWD   = 4'b0110;
  localparam logic [3:0] MOTOR_REV   = 4'b1001;
  localparam logic [3:0] MOTOR_PIV_L = 4'b1101;
  localparam logic [3:0] MOTOR_PIV_R = 4'b1011;
  localparam logic [3:0] MOTOR_BRAKE = 4'b1111;

  function automatic logic [3:0] motor_code(input state_e s);
    logic [3:0] code;
    case (s)
      ST_FWD:     code = MOTOR_FWD;
      ST_BACKOFF: code = MOTOR_REV;
      ST_TURN_L:  code = MOTOR_PIV_L;
      ST_TURN_R:  code = MOTOR_PIV_R;
      default:    code = MOTOR_BRAKE;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/ir_debounce.sv
// One IR channel: 2-flop synchroniser on the active-low pin, then a counter that
// accepts a new obstacle level only after DEB_CYC consecutive differing samples.
module ir_debounce #(
  parameter int DEB_CYC = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ir_n_i,
  output logic obst_o
);

  localparam int CW = (DEB_CYC < 2) ? 1 : $clog2(DEB_CYC + 1);

  logic          sync1_q, sync2_q;
  logic          flag_q, flag_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      flag_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= ~ir_n_i;
      sync2_q <= sync1_q;
      flag_q  <= flag_d;
      cnt_q   <= cnt_d;
    end
  end

  // Any sample agreeing with the current flag restarts the run.
  always_comb begin
    flag_d = flag_q;
    cnt_d  = '0;
    if (sync2_q != flag_q) begin
      if (cnt_q >= CW'(DEB_CYC - 1)) begin
        flag_d = sync2_q;
        cnt_d  = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  assign obst_o = flag_q;

endmodule

// File: rtl/obstacle_nav_fsm.sv
// Obstacle-avoidance controller: debounced IR inputs, tick prescaler, tick timer,
// retry counter and the drive FSM that owns the H-bridge motor lines.
module obstacle_nav_fsm
  import car_pkg::*;
#(
  parameter int              N_IR        = 4,
  parameter logic [N_IR-1:0] FRONT_MASK  = 4'b0001,
  parameter logic [N_IR-1:0] LEFT_MASK   = 4'b0010,
  parameter logic [N_IR-1:0] RIGHT_MASK  = 4'b0100,
  parameter logic [N_IR-1:0] REAR_MASK   = 4'b1000,
  parameter int              TICK_DIV    = 50000,
  parameter int              DEB_CYC     = 8,
  parameter int              START_TICKS = 10,
  parameter int              BACK_TICKS  = 20,
  parameter int              TURN_TICKS  = 15,
  parameter int              MAX_RETRY   = 3
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en,
  input  logic [N_IR-1:0] ir_n,
  output logic [3:0]      motor_fin,
  output logic [2:0]      state_o,
  output logic [N_IR-1:0] obst_o,
  output logic            stuck_o
);

  localparam int TMR_MAX = (START_TICKS > BACK_TICKS)
                         ? ((START_TICKS > TURN_TICKS) ? START_TICKS : TURN_TICKS)
                         : ((BACK_TICKS > TURN_TICKS) ? BACK_TICKS : TURN_TICKS);
  localparam int PW = $clog2(TICK_DIV);
  localparam int TW = (TMR_MAX < 1) ? 1 : $clog2(TMR_MAX + 1);
  localparam int RW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

  logic [N_IR-1:0] obst;
  logic            f_obst, l_obst, r_obst, b_obst;
  logic [PW-1:0]   presc_q, presc_d;
  logic            tick;
  logic [TW-1:0]   timer_q, timer_d;
  logic [RW-1:0]   retry_q, retry_d;
  logic            toggle_q, toggle_d;
  state_e          state_q, state_d;
  logic            reenter;
  logic [3:0]      motor_q;
  logic            stuck_q;

  genvar gi;
  generate
    for (gi = 0; gi < N_IR; gi++) begin : g_ir
      ir_debounce #(.DEB_CYC(DEB_CYC)) u_deb (
        .clk    (clk),
        .rst_n  (rst_n),
        .ir_n_i (ir_n[gi]),
        .obst_o (obst[gi])
      );
    end
  endgenerate

  assign f_obst = |(obst & FRONT_MASK);
  assign l_obst = |(obst & LEFT_MASK);
  assign r_obst = |(obst & RIGHT_MASK);
  assign b_obst = |(obst & REAR_MASK);

  // Free-running prescaler; state changes never disturb its phase.
  assign tick    = (presc_q == PW'(TICK_DIV - 1));
  assign presc_d = tick ? '0 : presc_q + 1'b1;

  always_comb begin
    state_d  = state_q;
    retry_d  = retry_q;
    toggle_d = toggle_q;
    reenter  = 1'b0;
    if (!en) begin
      state_d = ST_IDLE;
      retry_d = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (timer_q == TW'(START_TICKS)) begin
            state_d = ST_FWD;
            retry_d = '0;
          end
        end
        ST_FWD: begin
          if (f_obst || (l_obst && r_obst)) state_d = ST_BACKOFF;
          else if (l_obst)                  state_d = ST_TURN_R;
          else if (r_obst)                  state_d = ST_TURN_L;
        end
        ST_BACKOFF: begin
          if (timer_q == TW'(BACK_TICKS) || b_obst) begin
            if (l_obst && !r_obst)      state_d = ST_TURN_R;
            else if (r_obst && !l_obst) state_d = ST_TURN_L;
            else begin
              // Ambiguous side: alternate so repeated dead ends try both ways.
              state_d  = toggle_q ? ST_TURN_R : ST_TURN_L;
              toggle_d = ~toggle_q;
            end
          end
        end
        ST_TURN_L, ST_TURN_R: begin
          if (timer_q == TW'(TURN_TICKS)) begin
            if (!f_obst) begin
              state_d = ST_FWD;
              retry_d = '0;
            end else begin
              retry_d = (retry_q < RW'(MAX_RETRY)) ? retry_q + 1'b1 : retry_q;
              if (retry_q >= RW'(MAX_RETRY - 1)) state_d = ST_STUCK;
              else                               reenter = 1'b1;
            end
          end
        end
        ST_STUCK: ;
        default: begin
          state_d = ST_IDLE;
          retry_d = '0;
        end
      endcase
    end
  end

  always_comb begin
    timer_d = timer_q;
    if (!en || reenter || (state_d != state_q)) timer_d = '0;
    else if (tick && (timer_q != TW'(TMR_MAX))) timer_d = timer_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q  <= '0;
      timer_q  <= '0;
      retry_q  <= '0;
      toggle_q <= 1'b0;
      state_q  <= ST_IDLE;
      motor_q  <= MOTOR_BRAKE;
      stuck_q  <= 1'b0;
    end else begin
      presc_q  <= presc_d;
      timer_q  <= timer_d;
      retry_q  <= retry_d;
      toggle_q <= toggle_d;
      state_q  <= state_d;
      motor_q  <= motor_code(state_d);
      stuck_q  <= (state_d == ST_STUCK);
    end
  end

  assign motor_fin = motor_q;
  assign state_o   = state_q;
  assign obst_o    = obst;
  assign stuck_o   = stuck_q;

endmodule

// File: tb/tb_obstacle_nav_fsm.sv
// Directed bench for obstacle_nav_fsm with a fast prescaler and short debounce/timing.
module tb_obstacle_nav_fsm;

  localparam int N_IR = 4, TD = 4, DEB = 3, START = 2, BACK = 2, TURN = 3, MAXR = 2;
  localparam logic [3:0] M_FWD = 4'b0110, M_REV = 4'b1001, M_PL = 4'b1101,
                         M_PR = 4'b1011, M_BRK = 4'b1111;
  localparam logic [2:0] S_IDLE = 3'd0, S_FWD = 3'd1, S_BACK = 3'd2,
                         S_TL = 3'd3, S_TR = 3'd4, S_STUCK = 3'd5;
  // Entry-to-exit edge windows given the unknown prescaler phase.
  localparam int BACK_LO = (BACK - 1) * TD + 2, BACK_HI = BACK * TD + 1;
  localparam int TURN_LO = (TURN - 1) * TD + 2, TURN_HI = TURN * TD + 1;
  localparam int LAT     = 2 + DEB + 1;

  logic            clk = 1'b0;
  logic            rst_n, en;
  logic [N_IR-1:0] ir_n;
  logic [3:0]      motor_fin;
  logic [2:0]      state_o;
  logic [N_IR-1:0] obst_o;
  logic            stuck_o;

  int checks   = 0;
  int failures = 0;
  int n;
  logic seen;

  always #5 clk = ~clk;

  obstacle_nav_fsm #(
    .N_IR(N_IR), .FRONT_MASK(4'b0001), .LEFT_MASK(4'b0010), .RIGHT_MASK(4'b0100),
    .REAR_MASK(4'b1000), .TICK_DIV(TD), .DEB_CYC(DEB), .START_TICKS(START),
    .BACK_TICKS(BACK), .TURN_TICKS(TURN), .MAX_RETRY(MAXR)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .ir_n(ir_n),
    .motor_fin(motor_fin), .state_o(state_o), .obst_o(obst_o), .stuck_o(stuck_o)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  task automatic step(input int cnt);
    repeat (cnt) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_state(input string tag, input logic [2:0] target, input int maxc,
                            output int cnt);
    cnt = 0;
    while (state_o !== target && cnt < maxc) begin
      step(1);
      cnt++;
    end
    check_val(tag, 32'(state_o), 32'(target));
  endtask

  task automatic in_window(input string tag, input int val, input int lo, input int hi);
    check_val(tag, 32'(val >= lo && val <= hi), 32'd1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    en    = 1'b1;
    ir_n  = 4'hF;
    step(2);
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // 1: reset state and start-up delay
    do_reset();
    rst_n = 1'b0;
    step(1);
    check_val("rst_motor", 32'(motor_fin), 32'(M_BRK));
    check_val("rst_state", 32'(state_o), 32'(S_IDLE));
    check_val("rst_obst", 32'(obst_o), 32'd0);
    check_val("rst_stuck", 32'(stuck_o), 32'd0);
    rst_n = 1'b1;
    wait_state("start_fwd", S_FWD, 20, n);
    check_val("start_cycles", 32'(n), 32'(START * TD + 1));
    check_val("start_motor", 32'(motor_fin), 32'(M_FWD));

    // 2: glitch rejection, then a real front obstacle
    ir_n = 4'b1110;
    step(2);
    ir_n = 4'hF;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step(1);
      if (obst_o != 4'h0 || state_o != S_FWD) seen = 1'b1;
    end
    check_val("glitch_ignored", 32'(seen), 32'd0);
    ir_n = 4'b1110;
    step(4);
    check_val("deb_early", 32'(obst_o), 32'd0);
    step(1);
    check_val("deb_obst", 32'(obst_o), 32'h1);
    check_val("deb_lag_state", 32'(state_o), 32'(S_FWD));
    step(1);
    check_val("deb_backoff", 32'(state_o), 32'(S_BACK));
    check_val("deb_rev", 32'(motor_fin), 32'(M_REV));
    ir_n = 4'hF;
    wait_state("bo_turn_l", S_TL, 12, n);
    in_window("bo_len", n, BACK_LO, BACK_HI);
    check_val("bo_piv_l", 32'(motor_fin), 32'(M_PL));
    wait_state("bo_turn_fwd", S_FWD, 16, n);
    in_window("turn_len", n, TURN_LO, TURN_HI);

    // 3: side obstacles
    ir_n = 4'b1101;
    wait_state("left_turn_r", S_TR, 10, n);
    check_val("left_lat", 32'(n), 32'(LAT));
    check_val("left_piv_r", 32'(motor_fin), 32'(M_PR));
    ir_n = 4'hF;
    wait_state("left_clear_fwd", S_FWD, 16, n);
    in_window("left_turn_len", n, TURN_LO, TURN_HI);
    check_val("left_fwd_motor", 32'(motor_fin), 32'(M_FWD));
    ir_n = 4'b1011;
    wait_state("right_turn_l", S_TL, 10, n);
    check_val("right_piv_l", 32'(motor_fin), 32'(M_PL));
    ir_n = 4'hF;
    wait_state("right_clear_fwd", S_FWD, 16, n);
    ir_n = 4'b1001;
    wait_state("both_backoff", S_BACK, 10, n);
    check_val("both_lat", 32'(n), 32'(LAT));
    ir_n = 4'hF;
    wait_state("both_toggle_r", S_TR, 12, n);
    wait_state("both_fwd", S_FWD, 16, n);

    // 4: back-off toggle and rear abort from a fresh reset
    do_reset();
    wait_state("bo4_fwd", S_FWD, 20, n);
    ir_n = 4'b1110;
    wait_state("bo4_back1", S_BACK, 10, n);
    ir_n = 4'hF;
    wait_state("bo4_turn_l", S_TL, 12, n);
    in_window("bo4_len1", n, BACK_LO, BACK_HI);
    wait_state("bo4_fwd1", S_FWD, 16, n);
    ir_n = 4'b1110;
    wait_state("bo4_back2", S_BACK, 10, n);
    ir_n = 4'hF;
    wait_state("bo4_turn_r", S_TR, 12, n);
    check_val("bo4_piv_r", 32'(motor_fin), 32'(M_PR));
    wait_state("bo4_fwd2", S_FWD, 16, n);
    ir_n = 4'b0110;
    wait_state("rear_back", S_BACK, 10, n);
    step(1);
    check_val("rear_abort", 32'(state_o), 32'(S_TL));
    ir_n = 4'hF;
    wait_state("rear_fwd", S_FWD, 16, n);

    // 5: persistent front obstacle ends in STUCK
    ir_n = 4'b1110;
    wait_state("stk_back", S_BACK, 10, n);
    wait_state("stk_turn_r", S_TR, 12, n);
    wait_state("stk_stuck", S_STUCK, 30, n);
    in_window("stk_len", n, TURN_LO + TURN * TD, TURN_HI + TURN * TD);
    check_val("stk_flag", 32'(stuck_o), 32'd1);
    check_val("stk_motor", 32'(motor_fin), 32'(M_BRK));
    step(6);
    check_val("stk_hold", 32'(state_o), 32'(S_STUCK));
    en = 1'b0;
    step(1);
    check_val("stk_en_idle", 32'(state_o), 32'(S_IDLE));
    check_val("stk_en_flag", 32'(stuck_o), 32'd0);
    step(10);
    check_val("en_low_hold", 32'(state_o), 32'(S_IDLE));
    en   = 1'b1;
    ir_n = 4'hF;

    // 6: enable drop and async reset during a turn
    wait_state("m6_fwd", S_FWD, 20, n);
    ir_n = 4'b1101;
    wait_state("m6_turn", S_TR, 10, n);
    ir_n = 4'hF;
    step(3);
    en = 1'b0;
    step(1);
    check_val("m6_en_idle", 32'(state_o), 32'(S_IDLE));
    check_val("m6_en_brake", 32'(motor_fin), 32'(M_BRK));
    en = 1'b1;
    wait_state("m6_restart", S_FWD, 12, n);
    in_window("m6_restart_len", n, BACK_LO, BACK_HI);
    ir_n = 4'b1101;
    wait_state("m6_turn2", S_TR, 10, n);
    step(2);
    #3 rst_n = 1'b0;
    #1;
    check_val("arst_motor", 32'(motor_fin), 32'(M_BRK));
    check_val("arst_state", 32'(state_o), 32'(S_IDLE));
    check_val("arst_obst", 32'(obst_o), 32'd0);
    check_val("arst_stuck", 32'(stuck_o), 32'd0);
    ir_n = 4'hF;
    step(1);
    rst_n = 1'b1;
    wait_state("arst_fwd", S_FWD, 20, n);
    check_val("arst_counters", 32'(n), 32'(START * TD + 1));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
